// File: rtl/fetch_align_buffer_pkg.sv
// Shared parcel type, compressed-instruction predicate and default geometry
// for the fetch alignment buffer.
package c_ext_defs;

    localparam int FETCH_W_DEF   = 32;
    localparam int DEPTH_DEF     = 8;
    localparam int FETCH_PARCELS = FETCH_W_DEF / 16;
    localparam int PARCEL_IDX_W  = $clog2(DEPTH_DEF);

    typedef struct packed {
        logic [15:0] data;
        logic        exc;
    } type_parcel_s;

    // A parcel whose two low bits are not 2'b11 is a complete 16-bit instruction.
    function automatic logic is_comp_parcel(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the alignment buffer.
// The master modport is the front end / decode side, slave is the buffer.
interface fetch_align_buffer_if #(
    parameter int XLEN    = 32,
    parameter int FETCH_W = 32,
    parameter int DEPTH   = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               fetch_valid_i;
    logic               fetch_ready_o;
    logic [FETCH_W-1:0] fetch_data_i;
    logic               fetch_exc_i;
    logic               flush_i;
    logic [XLEN-1:0]    flush_pc_i;
    logic               instr_valid_o;
    logic               instr_ready_i;
    logic [31:0]        instr_o;
    logic [XLEN-1:0]    instr_pc_o;
    logic               instr_is_comp_o;
    logic               instr_exc_o;
    logic [CW-1:0]      count_o;

    modport master (
        output fetch_valid_i, fetch_data_i, fetch_exc_i, flush_i, flush_pc_i, instr_ready_i,
        input  fetch_ready_o, instr_valid_o, instr_o, instr_pc_o, instr_is_comp_o,
               instr_exc_o, count_o
    );

    modport slave (
        input  fetch_valid_i, fetch_data_i, fetch_exc_i, flush_i, flush_pc_i, instr_ready_i,
        output fetch_ready_o, instr_valid_o, instr_o, instr_pc_o, instr_is_comp_o,
               instr_exc_o, count_o
    );

endinterface

// File: rtl/fetch_parcel_fifo.sv
// Circular parcel store: P-parcel write at the tail (skipping leading parcels),
// two-parcel read window at the head, pop of one or two parcels per cycle.
module fetch_parcel_fifo
    import c_ext_defs::*;
#(
    parameter int DEPTH = 8,
    parameter int P     = 2,
    localparam int IW   = $clog2(DEPTH),
    localparam int CW   = IW + 1,
    localparam int SKW  = $clog2(P)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [SKW-1:0]         skip_i,
    input  type_parcel_s [P-1:0]   wr_parcels_i,
    input  logic                   pop_i,
    input  logic                   pop_two_i,
    output type_parcel_s           rd0_o,
    output type_parcel_s           rd1_o,
    output logic [CW-1:0]          count_o
);

    type_parcel_s mem [DEPTH];

    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] push_n, pop_n;

    always_comb begin
        push_n  = push_i ? CW'(P) - CW'(skip_i) : '0;
        pop_n   = pop_i ? (pop_two_i ? CW'(2) : CW'(1)) : '0;
        head_d  = head_q + IW'(pop_n);
        tail_d  = tail_q + IW'(push_n);
        count_d = count_q + push_n - pop_n;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Parcels below skip belong to bytes before the redirect target and are dropped.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            for (int i = 0; i < P; i++) begin
                if (i >= 32'(skip_i)) begin
                    mem[tail_q + IW'(i) - IW'(skip_i)] <= wr_parcels_i[i];
                end
            end
        end
    end

    assign rd0_o   = mem[head_q];
    assign rd1_o   = mem[head_q + IW'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_align_buffer.sv
// Instruction alignment queue: splits fetch words into parcels and issues one
// aligned 16- or 32-bit instruction per cycle with its PC and fault flag.
module fetch_align_buffer
    import c_ext_defs::*;
#(
    parameter int              XLEN     = 32,
    parameter int              FETCH_W  = 32,
    parameter int              DEPTH    = 8,
    parameter logic [XLEN-1:0] PC_RESET = XLEN'(32'h8000_0000)
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_align_buffer_if.slave bus
);

    localparam int P    = FETCH_W / 16;
    localparam int SKW  = $clog2(P);
    localparam int OFFW = $clog2(FETCH_W / 8);
    localparam int CW   = $clog2(DEPTH) + 1;

    type_parcel_s [P-1:0] wr_parcels;
    type_parcel_s         rd0, rd1;
    logic [CW-1:0]        count;

    logic [SKW-1:0]  skip_q, skip_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;

    logic        fetch_ready, push, pop, pop_two;
    logic        head_comp, head_fault;
    logic        instr_valid, instr_comp, instr_exc;
    logic [31:0] instr;

    for (genvar gi = 0; gi < P; gi++) begin : g_split
        assign wr_parcels[gi] = {bus.fetch_data_i[16*gi +: 16], bus.fetch_exc_i};
    end

    // Readiness looks only at the stored count, never at this cycle's pop.
    assign fetch_ready = count <= CW'(DEPTH - P);
    assign push        = bus.fetch_valid_i & fetch_ready & ~bus.flush_i;
    assign head_comp   = is_comp_parcel(rd0.data);
    assign head_fault  = rd0.exc;

    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_comp  = 1'b0;
        instr_exc   = 1'b0;
        if (!bus.flush_i && count != '0) begin
            if (head_fault) begin
                instr_valid = 1'b1;
                instr_comp  = 1'b1;
                instr_exc   = 1'b1;
            end else if (head_comp) begin
                instr_valid = 1'b1;
                instr       = {16'h0000, rd0.data};
                instr_comp  = 1'b1;
            end else if (count >= CW'(2)) begin
                instr_valid = 1'b1;
                instr       = {rd1.data, rd0.data};
                instr_exc   = rd1.exc;
            end
        end
    end

    assign pop     = instr_valid & bus.instr_ready_i;
    assign pop_two = ~head_fault & ~head_comp;

    always_comb begin
        head_pc_d = head_pc_q;
        skip_d    = skip_q;
        if (bus.flush_i) begin
            head_pc_d = bus.flush_pc_i;
            skip_d    = bus.flush_pc_i[OFFW-1:1];
        end else begin
            if (pop) begin
                head_pc_d = head_pc_q + (pop_two ? XLEN'(4) : XLEN'(2));
            end
            if (push) begin
                skip_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_pc_q <= PC_RESET;
            skip_q    <= '0;
        end else begin
            head_pc_q <= head_pc_d;
            skip_q    <= skip_d;
        end
    end

    fetch_parcel_fifo #(
        .DEPTH (DEPTH),
        .P     (P)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (bus.flush_i),
        .push_i       (push),
        .skip_i       (skip_q),
        .wr_parcels_i (wr_parcels),
        .pop_i        (pop),
        .pop_two_i    (pop_two),
        .rd0_o        (rd0),
        .rd1_o        (rd1),
        .count_o      (count)
    );

    assign bus.fetch_ready_o   = fetch_ready;
    assign bus.instr_valid_o   = instr_valid;
    assign bus.instr_o         = instr;
    assign bus.instr_pc_o      = head_pc_q;
    assign bus.instr_is_comp_o = instr_comp;
    assign bus.instr_exc_o     = instr_exc;
    assign bus.count_o         = count;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Scoreboard bench: a parcel-stream reference model predicts instructions,
// a negedge monitor compares every issued instruction and the status outputs.
module tb_fetch_align_buffer;
    import c_ext_defs::*;

    localparam int          XLEN     = 32;
    localparam int          FETCH_W  = 32;
    localparam int          DEPTH    = 8;
    localparam int          P        = FETCH_W / 16;
    localparam logic [31:0] PC_RESET = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_align_buffer_if #(.XLEN(XLEN), .FETCH_W(FETCH_W), .DEPTH(DEPTH)) bus ();

    fetch_align_buffer #(
        .XLEN     (XLEN),
        .FETCH_W  (FETCH_W),
        .DEPTH    (DEPTH),
        .PC_RESET (PC_RESET)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
        logic        exc;
        int          size;
    } exp_t;

    exp_t        exp_q[$];
    logic [16:0] pend[$];      // {exc, data} not yet forming a whole instruction
    logic [31:0] model_pc;     // PC of the first pending parcel
    int          model_count;
    int          model_skip;
    bit          mon_en;
    int          n_checks;
    int          n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Cut the pending parcel stream into instructions by the ISA length rule.
    task automatic decode();
        exp_t e;
        forever begin
            if (pend.size() == 0) break;
            if (pend[0][16]) begin
                e.instr = '0; e.comp = 1'b1; e.exc = 1'b1; e.size = 1;
            end else if (pend[0][1:0] != 2'b11) begin
                e.instr = {16'h0, pend[0][15:0]}; e.comp = 1'b1; e.exc = 1'b0; e.size = 1;
            end else if (pend.size() >= 2) begin
                e.instr = {pend[1][15:0], pend[0][15:0]}; e.comp = 1'b0;
                e.exc = pend[1][16]; e.size = 2;
            end else begin
                break;
            end
            e.pc = model_pc;
            model_pc = model_pc + 32'(2 * e.size);
            for (int k = 0; k < e.size; k++) void'(pend.pop_front());
            exp_q.push_back(e);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        model_pc    = PC_RESET;
        model_count = 0;
        model_skip  = 0;
    endtask

    // One cycle of stimulus; the accepted push or flush is recorded after the
    // monitor has sampled this cycle.
    task automatic step(input bit v, input logic [31:0] d, input bit e, input bit f,
                        input logic [31:0] fpc, input bit r);
        @(posedge clk);
        #1;
        bus.fetch_valid_i = v;
        bus.fetch_data_i  = d;
        bus.fetch_exc_i   = e;
        bus.flush_i       = f;
        bus.flush_pc_i    = fpc;
        bus.instr_ready_i = r;
        @(negedge clk);
        #1;
        if (f) begin
            exp_q.delete();
            pend.delete();
            model_count = 0;
            model_pc    = fpc;
            model_skip  = int'(fpc[1]);
        end else if (v && bus.fetch_ready_o) begin
            for (int i = model_skip; i < P; i++) pend.push_back({e, d[16*i +: 16]});
            model_count += P - model_skip;
            model_skip  = 0;
            decode();
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, r);
    endtask

    function automatic logic [15:0] rand_parcel();
        logic [15:0] p;
        p = 16'($urandom);
        if ($urandom_range(1, 0) == 0) begin
            if (p[1:0] == 2'b11) p[0] = 1'b0;
        end else begin
            p[1:0] = 2'b11;
        end
        return p;
    endfunction

    exp_t mon_e;
    bit   mon_exp_valid;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("count", 64'(bus.count_o), 64'(model_count));
            check("fetch_ready", 64'(bus.fetch_ready_o), 64'((DEPTH - model_count) >= P));
            mon_exp_valid = !bus.flush_i && exp_q.size() != 0;
            check("instr_valid", 64'(bus.instr_valid_o), 64'(mon_exp_valid));
            if (!bus.instr_valid_o) begin
                check("gated_outputs", {bus.instr_o, bus.instr_is_comp_o, bus.instr_exc_o}, 64'h0);
                if (!bus.flush_i && exp_q.size() == 0)
                    check("empty_pc", 64'(bus.instr_pc_o), 64'(model_pc));
            end else if (bus.instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_issue: got instr 0x%08h, expected none", bus.instr_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    model_count -= mon_e.size;
                    $display("issue pc=0x%08h instr=0x%08h comp=%0d exc=%0d",
                             bus.instr_pc_o, bus.instr_o, bus.instr_is_comp_o, bus.instr_exc_o);
                    check("instr", 64'(bus.instr_o), 64'(mon_e.instr));
                    check("instr_pc", 64'(bus.instr_pc_o), 64'(mon_e.pc));
                    check("is_comp", 64'(bus.instr_is_comp_o), 64'(mon_e.comp));
                    check("instr_exc", 64'(bus.instr_exc_o), 64'(mon_e.exc));
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        bus.fetch_valid_i = 1'b0;
        bus.fetch_data_i  = '0;
        bus.fetch_exc_i   = 1'b0;
        bus.flush_i       = 1'b0;
        bus.flush_pc_i    = '0;
        bus.instr_ready_i = 1'b0;
        model_reset();

        #12;
        check("rst_valid", 64'(bus.instr_valid_o), 64'h0);
        check("rst_ready", 64'(bus.fetch_ready_o), 64'h1);
        check("rst_count", 64'(bus.count_o), 64'h0);
        check("rst_instr", 64'(bus.instr_o), 64'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // two compressed instructions in one word
        step(1'b1, 32'h0001_4501, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(3, 1'b1);
        // 32-bit instruction straddling two fetch words
        step(1'b1, 32'h0513_4501, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(3, 1'b1);
        // redirect to a halfword target skips the first parcel
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0102, 1'b0);
        step(1'b1, 32'h0001_1111, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(2, 1'b1);
        // fill to full with decode stalled, fifth word must be dropped
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0513_0513, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(5, 1'b1);
        // wrap: place a 32-bit instruction across parcels 7 and 0
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0001_0001, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(6, 1'b1);
        step(1'b1, 32'h0513_0001, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(4, 1'b1);
        // faulting word, then flush and push together
        step(1'b1, 32'h0001_0001, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(3, 1'b1);
        step(1'b1, 32'h0001_4501, 1'b0, 1'b1, 32'h8000_0000, 1'b0);
        idle(2, 1'b0);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(9, 0) < 7, {rand_parcel(), rand_parcel()},
                 $urandom_range(19, 0) == 0, $urandom_range(39, 0) == 0,
                 {$urandom_range(32'hFFFF_FFFF, 0)} & 32'hFFFF_FFFE,
                 $urandom_range(9, 0) < 6);
        end

        // reset in the middle of traffic
        for (int n = 0; n < 6; n++) step(1'b1, {rand_parcel(), rand_parcel()}, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        bus.fetch_valid_i = 1'b0;
        bus.flush_i       = 1'b0;
        bus.instr_ready_i = 1'b0;
        #2;
        check("midrst_count", 64'(bus.count_o), 64'h0);
        check("midrst_valid", 64'(bus.instr_valid_o), 64'h0);
        check("midrst_ready", 64'(bus.fetch_ready_o), 64'h1);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(9, 0) < 7, {rand_parcel(), rand_parcel()},
                 $urandom_range(19, 0) == 0, 1'b0, 32'h0, $urandom_range(9, 0) < 6);
        end
        idle(12, 1'b1);
        check("drained", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
